// File: rtl/lif_if.sv
// Stimulus/threshold inputs and per-channel observation outputs of the LIF array.
// The master modport drives the stimulus side; the slave modport is the array itself.
interface lif_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             en;
  logic [WIDTH-1:0] stim_in;
  logic             thr_we;
  logic [WIDTH-1:0] thr_in;
  logic [CW-1:0]    ch_sel;
  logic [WIDTH-1:0] state_out;
  logic [N_CH-1:0]  spike;
  logic             frame_done;

  modport master (
    output en, stim_in, thr_we, thr_in,
    input  ch_sel, state_out, spike, frame_done
  );

  modport slave (
    input  en, stim_in, thr_we, thr_in,
    output ch_sel, state_out, spike, frame_done
  );
endinterface

// File: rtl/lif_array.sv
// Round-robin leaky integrate-and-fire array: one shared datapath, one channel per enabled clock.
// Optional refractory hold per channel is built when LIF_REFRACTORY_EN is defined.
module lif_array #(
  parameter int WIDTH      = 8,
  parameter int N_CH       = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int THRESH_RST = 50,
  parameter int REFRAC     = 2
) (
  input  logic clk,
  input  logic rst_n,
  lif_if.slave bus
);
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  if (N_CH < 2 || REFRAC < 0) begin : g_bad_cfg
    $error("lif_array: N_CH must be >= 2 and REFRAC non-negative");
  end

  logic [CW-1:0]    ch;
  logic [WIDTH-1:0] v [N_CH];
  logic [WIDTH-1:0] thr;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   sum;
  logic [N_CH-1:0]  spike_q;
  logic             fd;
  logic             refr;
  logic             fire;

  assign cur = v[ch];

  // cur - (cur >> LEAK_SHIFT) cannot go negative, so the extra bit only catches overflow
  always_comb begin
    sum = {1'b0, cur} - {1'b0, (cur >> LEAK_SHIFT)} + {1'b0, bus.stim_in};
    nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

`ifdef LIF_REFRACTORY_EN
  localparam int RCW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  logic [RCW-1:0] rc [N_CH];

  assign refr = (rc[ch] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) rc[i] <= '0;
    end else if (bus.en) begin
      if (refr)      rc[ch] <= rc[ch] - 1'b1;
      else if (fire) rc[ch] <= RCW'(REFRAC);
    end
  end
`else
  assign refr = 1'b0;
`endif

  // thr here is the pre-write value, so a same-edge threshold write only affects later visits
  assign fire = !refr && (nxt >= thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) v[i] <= '0;
      thr     <= WIDTH'(THRESH_RST);
      ch      <= '0;
      spike_q <= '0;
      fd      <= 1'b0;
    end else begin
      if (bus.thr_we) thr <= bus.thr_in;
      fd <= bus.en && (ch == LAST);
      if (bus.en) begin
        ch          <= (ch == LAST) ? '0 : ch + 1'b1;
        spike_q[ch] <= fire;
        v[ch]       <= (fire || refr) ? '0 : nxt;
      end
    end
  end

  assign bus.ch_sel     = ch;
  assign bus.state_out  = cur;
  assign bus.spike      = spike_q;
  assign bus.frame_done = fd;
endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: driver pushes expected post-edge outputs, a monitor pops and compares.
// Build with or without LIF_REFRACTORY_EN; expectations follow the same macro.
module tb_lif_array;
  localparam int W  = 8;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_if #(.WIDTH(W), .N_CH(NC)) bus ();

  lif_array #(.WIDTH(W), .N_CH(NC), .LEAK_SHIFT(3), .THRESH_RST(50), .REFRAC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int         ch;
    int         st;
    logic [3:0] spk;
    bit         fd;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  // Reference model state
  int         m_v [NC];
  int         m_rc[NC];
  int         m_thr;
  int         m_ch;
  logic [3:0] m_spk;
  bit         m_fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_v[i]  = 0;
      m_rc[i] = 0;
    end
    m_thr = 50;
    m_ch  = 0;
    m_spk = '0;
    m_fd  = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge after pushing the expectation.
  task automatic cyc(input bit e, input int stim, input bit we, input int ti);
    int   s;
    bit   held;
    exp_t x;
    bus.en      = e;
    bus.stim_in = W'(stim);
    bus.thr_we  = we;
    bus.thr_in  = W'(ti);
    @(posedge clk);
    m_fd = e && (m_ch == NC - 1);
    if (e) begin
      held = 1'b0;
`ifdef LIF_REFRACTORY_EN
      if (m_rc[m_ch] > 0) begin
        m_rc[m_ch]--;
        m_v[m_ch]   = 0;
        m_spk[m_ch] = 1'b0;
        held        = 1'b1;
      end
`endif
      if (!held) begin
        s = m_v[m_ch] - (m_v[m_ch] / 8) + stim;
        if (s > 255) s = 255;
        if (s >= m_thr) begin
          m_spk[m_ch] = 1'b1;
          m_v[m_ch]   = 0;
          m_rc[m_ch]  = 2;
        end else begin
          m_spk[m_ch] = 1'b0;
          m_v[m_ch]   = s;
        end
      end
      m_ch = (m_ch + 1) % NC;
    end
    if (we) m_thr = ti;
    x.ch  = m_ch;
    x.st  = m_v[m_ch];
    x.spk = m_spk;
    x.fd  = m_fd;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_ch_sel"},     bus.ch_sel, 0);
    chk({tag, "_spike"},      bus.spike, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_state_out"},  bus.state_out, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented cycle against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_ch_sel",     bus.ch_sel, e.ch);
        chk("sb_state_out",  bus.state_out, e.st);
        chk("sb_spike",      bus.spike, e.spk);
        chk("sb_frame_done", bus.frame_done, e.fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  initial begin
    int held_ch;
    bus.en = 1'b0; bus.stim_in = '0; bus.thr_we = 1'b0; bus.thr_in = '0;
    model_reset();
    #1;
    chk("por_ch_sel", bus.ch_sel, 0);
    chk("por_spike", bus.spike, 0);
    chk("por_state_out", bus.state_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Integration: 20 into channel 0, spikes at visit 3 (54 >= 50)
    for (int k = 0; k < 24; k++) begin
      cyc(1'b1, (m_ch == 0) ? 20 : 0, 1'b0, 0);
      if (k == 3)  chk("v0_after_visit1", bus.state_out, 20);
      if (k == 7)  chk("v0_after_visit2", bus.state_out, 38);
      if (k == 8)  chk("spike0_visit3", bus.spike[0], 1);
`ifdef LIF_REFRACTORY_EN
      if (k == 15) chk("v0_after_visit4", bus.state_out, 0);
      if (k == 16) chk("spike0_visit5", bus.spike[0], 0);
      if (k == 23) chk("v0_after_visit6", bus.state_out, 20);
`else
      if (k == 15) chk("v0_after_visit4", bus.state_out, 20);
`endif
    end

    // Saturation: threshold written while disabled, then 200 into channel 1
    cyc(1'b0, 0, 1'b1, 255);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, (m_ch == 1) ? 200 : 0, 1'b0, 0);
      if (k == 1) chk("spike1_sat_visit1", bus.spike[1], 0);
      if (k == 4) chk("v1_sat_visit1", bus.state_out, 200);
      if (k == 5) chk("spike1_sat_visit2", bus.spike[1], 1);
    end

    // Enable gating mid-frame
    cyc(1'b1, 30, 1'b0, 0);
    cyc(1'b1, 30, 1'b0, 0);
    held_ch = m_ch;
    for (int k = 0; k < 5; k++) cyc(1'b0, 99, 1'b0, 0);
    chk("gated_ch_sel", bus.ch_sel, held_ch);
    for (int k = 0; k < 6; k++) cyc(1'b1, 10, 1'b0, 0);

    // Reset mid-sweep, then first enabled edge must process channel 0
    cyc(1'b1, 0, 1'b0, 0);
    reset_check("rst_mid");
    cyc(1'b1, 0, 1'b0, 0);
    chk("post_rst_first_ch", bus.ch_sel, 1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 0, 1'b0, 0);

    // Threshold race on channel 2: v=40, stim 15 -> 50 vs old thr 50
    for (int k = 0; k < 4; k++) cyc(1'b1, (k == 2) ? 40 : 0, 1'b0, 0);
    cyc(1'b1, 0, 1'b0, 0);
    cyc(1'b1, 0, 1'b0, 0);
    chk("v2_before_race", bus.state_out, 40);
    cyc(1'b1, 15, 1'b1, 80);
    chk("spike2_race_old_thr", bus.spike[2], 1);
    cyc(1'b1, 0, 1'b0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, (m_ch == 2) ? 60 : 0, 1'b0, 0);
      if (k == 2) chk("spike2_new_thr", bus.spike[2], 0);
    end

    bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/lif_array.md
# lif_array

Time-multiplexed array of leaky integrate-and-fire neurons with a configurable width, channel count and leak, plus an optional refractory period. One shared update datapath visits the channels round-robin, one channel per enabled clock. The channel visited in a cycle is exposed on `ch_sel`, so the surrounding logic supplies that channel's stimulus in the same cycle. The block is the parametrised successor to the single-neuron core and drives per-channel spike flags to the output pins.

## Interface
- `WIDTH`, 8: membrane, stimulus and threshold width in bits.
- `N_CH`, 4: number of neurons; must be ≥2.
- `LEAK_SHIFT`, 3: leak per update is `state >> LEAK_SHIFT`.
- `THRESH_RST`, 50: threshold value after reset.
- `REFRAC`, 2: refractory length in updates of the same channel; used only with the macro defined.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  advance enable; when low, nothing updates and `ch_sel` holds.
- `stim_in`  in  WIDTH  stimulus for channel `ch_sel`; unsigned.
- `thr_we`  in  1  threshold write strobe.
- `thr_in`  in  WIDTH  new global threshold.
- `ch_sel`  out  clog2(N_CH)  channel processed at the next enabled edge.
- `state_out`  out  WIDTH  membrane of channel `ch_sel`; combinational mux of registers.
- `spike`  out  N_CH  per-channel spike flags.
- `frame_done`  out  1  one-cycle pulse after channel N_CH-1 updates.

## Operation
- Storage:
  - `N_CH` membrane registers `v[i]`.
  - One threshold register `thr`.
  - The channel counter, the `spike` vector and the `frame_done` flop.
  - With the macro: `N_CH` refractory counters `rc[i]`, each clog2(REFRAC+1) bits.
- Update on an edge with `en`=1, for channel c = `ch_sel`:
  - Compute `sum = v[c] - (v[c] >> LEAK_SHIFT) + stim_in` in WIDTH+1 bits.
  - Saturate: `nxt = sum[WIDTH] ? all-ones : sum[WIDTH-1:0]`.
  - If `nxt >= thr`: set `spike[c]`=1 and `v[c]`=0.
  - Otherwise: set `spike[c]`=0 and `v[c]`=`nxt`.
  - Only bit c of `spike` changes. Each bit holds until the next visit to that channel.
- Channel counter: increments on each enabled edge and wraps from N_CH-1 to 0.
- `frame_done`: registered; equals 1 for the cycle after the enabled edge that updated channel N_CH-1, and 0 otherwise, including when `en`=0.
- Threshold write: on an edge with `thr_we`=1, `thr` takes `thr_in`.
  - A write on the same edge as an update does not affect that update; the comparison uses the old `thr`.
  - A write is accepted regardless of `en`.
- `thr`=0: every non-refractory update spikes.
- Leak never underflows, because `v >> LEAK_SHIFT` ≤ `v`.
- Reset (`rst_n`=0), applied asynchronously:
  - All `v[i]`=0 and `rc[i]`=0.
  - `thr`=THRESH_RST.
  - `ch_sel`=0, `spike`=0, `frame_done`=0, so `state_out`=0.
- Reset mid-sweep discards the partial frame. The first enabled edge after release processes channel 0.

## Timing
- Per-channel update latency: 1 clock. `v[c]` and `spike[c]` are valid the cycle after the edge.
- `state_out` follows `ch_sel` combinationally. It shows the pre-update value of the channel about to be processed.
- Full frame: N_CH enabled cycles. A gapped `en` stretches the frame without losing ordering.
- Reset assertion clears all outputs immediately, without waiting for a clock. Release is synchronised by the environment; the first edge after release may update.

## Configuration
- Macro: `LIF_REFRACTORY_EN`.
- Defined:
  - On a spike, `rc[c]` loads REFRAC.
  - On a visit with `rc[c]`>0: `v[c]` stays 0, `stim_in` is ignored, `spike[c]`=0 and `rc[c]` decrements.
  - The threshold comparison is skipped for that visit.
- Undefined:
  - No `rc` storage; REFRAC is ignored.
  - Every visit performs the normal update.

## Test plan
- Reset check: drive `rst_n` low between clock edges. Required response: `ch_sel`, `spike`, `frame_done` and `state_out` go to 0 immediately, and `thr`=50.
- Integration (defaults, `en`=1, `stim_in`=20 for channel 0, 0 for the others):
  - Channel 0 takes 20 at visit 1 and 38 at visit 2.
  - At visit 3, `nxt`=54 ≥ 50, so `spike[0]`=1 and `v[0]`=0.
  - `frame_done` pulses once every 4 cycles.
- Refractory, with `LIF_REFRACTORY_EN`, continuing the integration case:
  - Visits 4 and 5 hold `v[0]`=0 with `spike[0]`=0.
  - Visit 6 gives `v[0]`=20.
  - Without the macro, visit 4 gives `v[0]`=20.
- Saturation: write `thr`=255, then drive channel 1 with `stim_in`=200.
  - Visit 1 gives 200 with no spike.
  - Visit 2 computes 375, which saturates to 255; `spike[1]`=1 and `v[1]`=0.
- Enable gating: hold `en`=0 for 5 cycles mid-frame. Required response: `ch_sel`, all `v` and `spike` are unchanged and `frame_done` stays 0; after `en` returns to 1, the sweep resumes at the held channel.
- Threshold race: with `v[2]`=40 and `stim_in`=15, write `thr_in`=80 on channel 2's update edge.
  - `nxt`=50 is compared against the old value 50, so `spike[2]`=1.
  - The next visit compares against 80.
